// File: rtl/ibuf_decode.sv
// ibuf_decode: circular instruction buffer that pre-decodes each MIPS instruction as it is enqueued.
module ibuf_decode #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_dst,
  output logic [31:0]      out_imm,
  output logic [2:0]       out_class,
  input  logic             flush,
  input  logic             flush_keep_head,
  output logic [PTR_W:0]   count
);
  logic [31:0]    instr_q [DEPTH];
  logic [31:0]    pc_q    [DEPTH];
  logic [4:0]     dst_q   [DEPTH];
  logic [31:0]    imm_q   [DEPTH];
  logic [2:0]     cls_q   [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, head_adv;
  logic [PTR_W:0]   count_q, count_d;
  logic push, pop, keep;
  logic [5:0]  op, fn;
  logic [4:0]  rt, rd;
  logic [31:0] sext, zext;
  logic [4:0]  dec_dst;
  logic [31:0] dec_imm;
  logic [2:0]  dec_cls;
  assign op   = in_instr[31:26];
  assign fn   = in_instr[5:0];
  assign rt   = in_instr[20:16];
  assign rd   = in_instr[15:11];
  assign sext = {{16{in_instr[15]}}, in_instr[15:0]};
  assign zext = {16'b0, in_instr[15:0]};
  always_comb begin
    dec_dst = '0;
    dec_imm = '0;
    dec_cls = 3'd7;
    if (op == 6'h00) begin
      if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, [6'h20:6'h27], 6'h2a, 6'h2b}) begin
        dec_cls = 3'd0;
        dec_dst = rd;
      end else if (fn == 6'h08) begin
        dec_cls = 3'd4;
      end else if (fn == 6'h09) begin
        dec_cls = 3'd4;
        dec_dst = rd;
      end else if (fn inside {6'h10, 6'h12}) begin
        dec_cls = 3'd5;
        dec_dst = rd;
      end else if (fn inside {6'h11, 6'h13, [6'h18:6'h1b]}) begin
        dec_cls = 3'd5;
      end
    end else if (op == 6'h01) begin
      // REGIMM: only BLTZ/BGEZ and their linking forms are recognised
      if (rt inside {5'h00, 5'h01, 5'h10, 5'h11}) begin
        dec_cls = 3'd3;
        dec_imm = sext;
        dec_dst = rt[4] ? 5'd31 : 5'd0;
      end
    end else if (op inside {6'h02, 6'h03}) begin
      dec_cls = 3'd4;
      dec_imm = {4'b0, in_instr[25:0], 2'b00};
      dec_dst = op[0] ? 5'd31 : 5'd0;
    end else if (op inside {[6'h04:6'h07]}) begin
      dec_cls = 3'd3;
      dec_imm = sext;
    end else if (op inside {[6'h09:6'h0f]}) begin
      dec_cls = 3'd0;
      dec_dst = rt;
      dec_imm = op == 6'h0f ? {in_instr[15:0], 16'b0} : op inside {[6'h0c:6'h0e]} ? zext : sext;
    end else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin
      dec_cls = 3'd1;
      dec_dst = rt;
      dec_imm = sext;
    end else if (op inside {6'h28, 6'h29, 6'h2b}) begin
      dec_cls = 3'd2;
      dec_imm = sext;
    end
  end
  assign in_ready  = count_q < (PTR_W+1)'(DEPTH);
  assign out_valid = count_q != '0;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;
  assign head_adv  = head_q + PTR_W'(pop);
  assign keep      = count_q > (PTR_W+1)'(pop);
  always_comb begin
    head_d  = (flush & ~flush_keep_head) ? '0 : head_adv;
    tail_d  = !flush ? tail_q + PTR_W'(push) : !flush_keep_head ? '0 : keep ? head_adv + PTR_W'(1) : head_adv;
    count_d = !flush ? count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop) : (flush_keep_head & keep) ? (PTR_W+1)'(1) : '0;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
        dst_q[i]   <= '0;
        imm_q[i]   <= '0;
        cls_q[i]   <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) begin
        instr_q[tail_q] <= in_instr;
        pc_q[tail_q]    <= in_pc;
        dst_q[tail_q]   <= dec_dst;
        imm_q[tail_q]   <= dec_imm;
        cls_q[tail_q]   <= dec_cls;
      end
    end
  end
  assign out_instr = instr_q[head_q];
  assign out_pc    = pc_q[head_q];
  assign out_rs    = out_instr[25:21];
  assign out_rt    = out_instr[20:16];
  assign out_dst   = dst_q[head_q];
  assign out_imm   = imm_q[head_q];
  assign out_class = cls_q[head_q];
  assign count     = count_q;
endmodule

// File: tb/tb_ibuf_decode.sv
// tb_ibuf_decode: directed vectors for the pre-decoding instruction buffer.
module tb_ibuf_decode;
  logic        clk = 0, resetn = 0;
  logic        in_valid = 0, out_ready = 0, flush = 0, flush_keep_head = 0;
  logic [31:0] in_instr = 0, in_pc = 0;
  logic        in_ready, out_valid;
  logic [31:0] out_instr, out_pc, out_imm;
  logic [4:0]  out_rs, out_rt, out_dst;
  logic [2:0]  out_class;
  logic [2:0]  count;
  int n_checks = 0, n_fail = 0;
  ibuf_decode #(.DEPTH(4)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_rs(out_rs), .out_rt(out_rt),
    .out_dst(out_dst), .out_imm(out_imm), .out_class(out_class),
    .flush(flush), .flush_keep_head(flush_keep_head), .count(count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1; in_instr = ins; in_pc = pc;
    tick();
    in_valid = 0;
  endtask
  task automatic pop();
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask
  logic [31:0] v_ins [12] = '{32'h3C01ABCD, 32'h8C220010, 32'hAC22FFFC, 32'h0C100004,
                              32'hFC000000, 32'h0611FFFE, 32'h03E00008, 32'h00001812,
                              32'h00851021, 32'h3082FFFF, 32'h1000FFFF, 32'h00850018};
  logic [31:0] v_dst [12] = '{1, 2, 0, 31, 0, 31, 0, 3, 2, 2, 0, 0};
  logic [31:0] v_imm [12] = '{32'hABCD0000, 32'h00000010, 32'hFFFFFFFC, 32'h00400010,
                              0, 32'hFFFFFFFE, 0, 0, 0, 32'h0000FFFF, 32'hFFFFFFFF, 0};
  logic [31:0] v_cls [12] = '{0, 1, 2, 4, 7, 3, 4, 5, 0, 0, 3, 5};
  logic [31:0] w;
  initial begin
    #12;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_ready", 32'(in_ready), 1);
    check("rst_count", 32'(count), 0);
    check("rst_instr", out_instr, 0);
    check("rst_pc", out_pc, 0);
    check("rst_dst", 32'(out_dst), 0);
    check("rst_imm", out_imm, 0);
    check("rst_class", 32'(out_class), 0);
    resetn = 1;
    tick();
    push(32'h24080005, 32'hBFC00000);
    check("addiu_valid", 32'(out_valid), 1);
    check("addiu_pc", out_pc, 32'hBFC00000);
    check("addiu_rt", 32'(out_rt), 8);
    check("addiu_dst", 32'(out_dst), 8);
    check("addiu_imm", out_imm, 5);
    check("addiu_class", 32'(out_class), 0);
    check("addiu_count", 32'(count), 1);
    pop();
    check("drain_count", 32'(count), 0);
    for (int i = 0; i < 4; i++) push(32'h24080000 + i, 32'h100 + 4 * i);
    check("full_count", 32'(count), 4);
    check("full_ready", 32'(in_ready), 0);
    in_valid = 1; in_instr = 32'h24080009; in_pc = 32'h999;
    pop();
    in_valid = 0;
    check("fullpop_count", 32'(count), 3);
    check("fullpop_head", out_pc, 32'h104);
    for (int k = 0; k < 8; k++) begin
      check("wrap_order", out_pc, 32'h104 + 4 * k);
      in_valid = 1; in_instr = 32'h24080000; in_pc = 32'h110 + 4 * k;
      pop();
      in_valid = 0;
    end
    check("wrap_count", 32'(count), 3);
    for (int k = 0; k < 3; k++) begin
      check("wrap_drain", out_pc, 32'h124 + 4 * k);
      pop();
    end
    check("wrap_empty", 32'(out_valid), 0);
    for (int i = 0; i < 12; i++) begin
      push(v_ins[i], 32'h400 + 4 * i);
      w = v_ins[i];
      check($sformatf("dec%0d_instr", i), out_instr, w);
      check($sformatf("dec%0d_rs", i), 32'(out_rs), 32'(w[25:21]));
      check($sformatf("dec%0d_dst", i), 32'(out_dst), v_dst[i]);
      check($sformatf("dec%0d_imm", i), out_imm, v_imm[i]);
      check($sformatf("dec%0d_class", i), 32'(out_class), v_cls[i]);
      pop();
    end
    push(32'h10000002, 32'h200);
    push(32'h00000000, 32'h204);
    push(32'h24080001, 32'h208);
    check("keep_pre_count", 32'(count), 3);
    check("keep_pop_beq", out_pc, 32'h200);
    flush = 1; flush_keep_head = 1; in_valid = 1; in_instr = 32'h24080002; in_pc = 32'h20C;
    pop();
    flush = 0; flush_keep_head = 0; in_valid = 0;
    check("keep_count", 32'(count), 1);
    check("keep_head", out_pc, 32'h204);
    pop();
    check("keep_no_push", 32'(out_valid), 0);
    push(32'h24080003, 32'h300);
    flush = 1; flush_keep_head = 1;
    pop();
    flush = 0; flush_keep_head = 0;
    check("keep_none_count", 32'(count), 0);
    push(32'h24080004, 32'h304);
    check("keep_none_head", out_pc, 32'h304);
    check("keep_none_cnt1", 32'(count), 1);
    pop();
    for (int i = 0; i < 4; i++) push(32'h24080000, 32'h500 + 4 * i);
    flush = 1; in_valid = 1; in_pc = 32'h510;
    tick();
    flush = 0; in_valid = 0;
    check("flush_count", 32'(count), 0);
    check("flush_valid", 32'(out_valid), 0);
    check("flush_ready", 32'(in_ready), 1);
    push(32'h24080005, 32'h600);
    check("flush_repush", out_pc, 32'h600);
    push(32'h8C220010, 32'h604);
    resetn = 0;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_count", 32'(count), 0);
    check("arst_instr", out_instr, 0);
    check("arst_pc", out_pc, 0);
    check("arst_dst", 32'(out_dst), 0);
    check("arst_imm", out_imm, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ibuf_decode.md
Name: ibuf_decode

Overview:
- Parametrised instruction buffer with registered pre-decode, placed between fetch and the decode/issue stage of the MIPS pipeline.
- Each fetched instruction is pre-decoded once at enqueue time, and its fields are stored alongside it in a circular queue.
- Decode therefore sees register indices, destination, immediate and class directly from a flop.
- Supports pipeline flush with optional retention of the branch delay slot.

Parameters:
DEPTH, 4, queue entries; power of two, >=2
PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
in_valid  in  1  fetch offers instruction
in_ready  out  1  queue can accept; equals (count < DEPTH)
in_instr  in  32  instruction word
in_pc  in  32  instruction PC
out_valid  out  1  head entry valid; equals (count != 0)
out_ready  in  1  decode consumes head
out_instr  out  32  head instruction
out_pc  out  32  head PC
out_rs  out  5  instr[25:21]
out_rt  out  5  instr[20:16]
out_dst  out  5  write-back register, 0 = none
out_imm  out  32  pre-formatted immediate
out_class  out  3  0 ALU, 1 load, 2 store, 3 branch, 4 jump, 5 hi/lo, 7 unknown
flush  in  1  drop queue contents
flush_keep_head  in  1  with flush: retain the delay-slot entry
count  out  PTR_W+1  occupancy

Behaviour:
- Reset (async, resetn=0): head pointer, tail pointer and count = 0; all storage = 0; out_valid=0, in_ready=1, and all out_* fields read as 0.
- Push when in_valid & in_ready & !flush. Pop when out_valid & out_ready. Both may occur in one cycle; count is unchanged when both fire.
- Latency: a push in cycle N is visible on out_* in cycle N+1. There is no empty-queue bypass.
- in_ready depends only on count, never on out_ready. A full queue with a simultaneous pop still refuses the push.
- Outputs are read from the storage at the head pointer (first-word fall-through). Pointers wrap modulo DEPTH.
- Pre-decode, computed combinationally at the write port and stored with the entry:
  - out_dst: rd for RTYPE ALU/shift/MFHI/MFLO/JALR; 0 for JR, MTHI, MTLO, MULT(U), DIV(U); rt for ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LUI and loads; 31 for JAL, BLTZAL, BGEZAL; 0 otherwise.
  - out_imm: sign-extended instr[15:0] for ADDIU, SLTI, SLTIU, loads, stores and branches; zero-extended for ANDI, ORI, XORI; {instr[15:0],16'b0} for LUI; {4'b0, instr[25:0], 2'b00} for J/JAL; 0 for RTYPE.
  - out_class:
    - 0: ALU.
    - 1: LW, LH, LHU, LB, LBU.
    - 2: SW, SH, SB.
    - 3: BEQ, BNE, BGTZ, BLEZ, and REGIMM with rt in {BLTZ, BGEZ, BLTZAL, BGEZAL}.
    - 4: J, JAL, JR, JALR.
    - 5: MFHI, MFLO, MTHI, MTLO, MULT, MULTU, DIV, DIVU.
    - 7: any unlisted opcode/funct. Class 7 carries dst=0 and imm=0.
- Flush (synchronous, highest priority over push):
  - flush & !flush_keep_head: count:=0; head and tail reset to 0; any push that cycle is discarded.
  - flush & flush_keep_head: the retained entry is head if no pop this cycle, or head+1 if a pop fires.
    - If the retained entry exists (count > pop), count:=1, head advances normally and tail := retained slot + 1.
    - Otherwise count:=0 and both pointers are set equal to the advanced head.
  - A pop in the flush cycle always completes; decode receives that instruction.
- An async reset in mid-flush or mid-transfer simply returns the block to the reset state. No partial entry survives.
- Storage contents of empty slots are don't-care, but out_* must be 0 after reset until the first push.

Test Plan:
- Reset, then push instr 0x24080005 (ADDIU $8,$0,5) at PC 0xBFC00000 -> next cycle out_valid=1, out_dst=8, out_imm=0x00000005, out_class=0, count=1.
- Push DEPTH=4 entries with out_ready=0 -> count=4, in_ready=0. Next cycle in_valid=1, out_ready=1 -> one pop, no push, count=3. Wrap: 8 more push/pop pairs keep FIFO order by PC.
- Push LUI 0x3C01ABCD, LW 0x8C220010, SW 0xAC22FFFC, JAL 0x0C100004 -> imm 0xABCD0000, dst 1, class 0; imm 0x00000010, dst 2, class 1; imm 0xFFFFFFFC, dst 0, class 2; imm 0x00400010, dst 31, class 4.
- Queue holds 3 entries (BEQ, delay slot, X). Assert flush+flush_keep_head with out_ready=1 -> BEQ popped, next cycle count=1 with the delay slot at head. A push in the flush cycle is absent.
- flush without keep on a full queue with in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1. Deassert resetn mid-stream -> all outputs 0 immediately.
- Illegal opcode 0xFC000000 -> out_class=7, out_dst=0, out_imm=0. REGIMM BGEZAL 0x0611FFFE -> class 3, dst 31, imm 0xFFFFFFFE.
